// File: rtl/color_capture_ctrl.sv
// color_capture_ctrl: clears the colour detector, gates one camera frame into it, drains,
// then snapshots the nine cell colours until enough consecutive snapshots agree or attempts run out.
module color_capture_ctrl #(
  parameter int FRAME_PIXELS  = 307200,
  parameter int CLR_CYCLES    = 2,
  parameter int DRAIN_CYCLES  = 16,
  parameter int STABLE_FRAMES = 3,
  parameter int MAX_FRAMES    = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  input  logic        i_sof,
  output logic [15:0] o_det_data,
  output logic        o_det_valid,
  output logic        o_det_rstn,
  input  logic [26:0] i_colors,
  output logic [26:0] o_colors,
  output logic        o_stable,
  output logic        o_busy,
  output logic        o_done,
  input  logic        i_ack
);
  localparam int PW   = $clog2(FRAME_PIXELS + 1);
  localparam int FW   = $clog2(MAX_FRAMES + 1);
  localparam int CMAX = CLR_CYCLES > DRAIN_CYCLES ? CLR_CYCLES : DRAIN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(FRAME_PIXELS - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] DRN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [FW-1:0] STABLE_N = FW'(STABLE_FRAMES);
  localparam logic [FW-1:0] MAX_N    = FW'(MAX_FRAMES);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SOF, STREAM, DRAIN, COMPARE, DONE} state_t;

  state_t        r_state, w_next;
  logic [PW-1:0] r_pix;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_att, r_match, w_att_nx, w_match_nx;
  logic [26:0]   r_snap, r_colors;
  logic [15:0]   r_det_data;
  logic          r_det_valid, r_det_rstn, r_busy, r_done, r_stable;
  logic          w_sof_px, w_same, w_fwd, w_busy, w_det_rstn, w_done;

  assign w_sof_px   = i_valid && i_sof;
  assign w_same     = (i_colors == r_snap) && (r_match != '0);
  assign w_match_nx = w_same ? r_match + 1'b1 : FW'(1);
  assign w_att_nx   = r_att + 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = i_start ? CLEAR : IDLE;
      CLEAR:    w_next = r_cnt == CLR_LAST ? WAIT_SOF : CLEAR;
      WAIT_SOF: w_next = w_sof_px ? (FRAME_PIXELS == 1 ? DRAIN : STREAM) : WAIT_SOF;
      STREAM:   w_next = w_sof_px ? CLEAR : (i_valid && r_pix == PIX_LAST) ? DRAIN : STREAM;
      DRAIN:    w_next = r_cnt == DRN_LAST ? COMPARE : DRAIN;
      COMPARE:  w_next = (w_match_nx == STABLE_N || w_att_nx == MAX_N) ? DONE : CLEAR;
      DONE:     w_next = i_ack ? IDLE : DONE;
      default:  w_next = IDLE;
    endcase
    if (i_abort) w_next = IDLE;
  end

  // status outputs are registered from the next state so they line up with the state register
  always_comb begin
    w_fwd      = !i_abort && i_valid && (r_state == WAIT_SOF ? i_sof : (r_state == STREAM && !i_sof));
    w_busy     = w_next != IDLE;
    w_det_rstn = w_next != CLEAR;
    w_done     = w_next == DONE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= IDLE;
      r_pix       <= '0;
      r_cnt       <= '0;
      r_att       <= '0;
      r_match     <= '0;
      r_snap      <= '0;
      r_colors    <= '0;
      r_stable    <= 1'b0;
      r_det_data  <= '0;
      r_det_valid <= 1'b0;
      r_det_rstn  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= (w_next == r_state && (r_state == CLEAR || r_state == DRAIN)) ? r_cnt + 1'b1 : '0;
      r_det_valid <= w_fwd;
      r_det_rstn  <= w_det_rstn;
      r_busy      <= w_busy;
      r_done      <= w_done;
      if (w_fwd) begin
        r_det_data <= i_data;
        r_pix      <= r_state == WAIT_SOF ? PW'(1) : r_pix + 1'b1;
      end
      if (r_state == IDLE && w_next == CLEAR) begin
        r_att   <= '0;
        r_match <= '0;
      end
      if (r_state == COMPARE && !i_abort) begin
        r_att   <= w_att_nx;
        r_match <= w_match_nx;
        r_snap  <= i_colors;
        if (w_next == DONE) begin
          r_colors <= i_colors;
          r_stable <= w_match_nx == STABLE_N;
        end
      end
    end
  end

  assign o_det_data  = r_det_data;
  assign o_det_valid = r_det_valid;
  assign o_det_rstn  = r_det_rstn;
  assign o_colors    = r_colors;
  assign o_stable    = r_stable;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
endmodule

// File: tb/tb_color_capture_ctrl.sv
// tb_color_capture_ctrl: randomized capture sessions checked every cycle against a behavioural model,
// plus literal expectations for the directed scenarios.
module tb_color_capture_ctrl;
  localparam int FP = 16, CLR = 2, DRN = 4, STB = 2, MAXF = 4;
  localparam logic [26:0] CA = 27'h5A5A5A5, CB = 27'h2ABCDEF, CN = 27'h1234567;

  logic i_clk = 0, i_rstn = 0, i_start = 0, i_abort = 0, i_valid = 0, i_sof = 0, i_ack = 0;
  logic [15:0] i_data = 0;
  logic [26:0] i_colors = 0;
  logic [15:0] o_det_data;
  logic o_det_valid, o_det_rstn, o_stable, o_busy, o_done;
  logic [26:0] o_colors;

  always #5 i_clk = ~i_clk;

  color_capture_ctrl #(.FRAME_PIXELS(FP), .CLR_CYCLES(CLR), .DRAIN_CYCLES(DRN),
                       .STABLE_FRAMES(STB), .MAX_FRAMES(MAXF)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_abort(i_abort),
    .i_data(i_data), .i_valid(i_valid), .i_sof(i_sof),
    .o_det_data(o_det_data), .o_det_valid(o_det_valid), .o_det_rstn(o_det_rstn),
    .i_colors(i_colors), .o_colors(o_colors), .o_stable(o_stable),
    .o_busy(o_busy), .o_done(o_done), .i_ack(i_ack));

  int checks = 0, errors = 0;
  int n_valid = 0, n_low = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus remaining-cycle budgets and a history of snapshots.
  int ph, left;
  logic [26:0] hist[$];
  logic [26:0] e_colors, e_data;
  logic e_valid, e_rstn, e_busy, e_done, e_stable;
  bit m_ok = 0;

  function automatic bit agree();
    if (hist.size() < STB) return 0;
    for (int i = 1; i < STB; i++)
      if (hist[hist.size()-1-i] != hist[hist.size()-1]) return 0;
    return 1;
  endfunction

  always @(posedge i_clk) begin
    e_valid = 0;
    if (!i_rstn) begin
      ph = 0; e_colors = 0; e_stable = 0; e_data = 0; hist.delete(); m_ok = 1;
    end else if (i_abort) ph = 0;
    else case (ph)
      0: if (i_start) begin ph = 1; left = CLR; hist.delete(); end
      1: begin left = left - 1; if (left == 0) ph = 2; end
      2: if (i_valid && i_sof) begin
           e_valid = 1; e_data = {11'd0, i_data}; left = FP - 1; ph = 3;
           if (left == 0) begin ph = 4; left = DRN; end
         end
      3: if (i_valid) begin
           if (i_sof) begin ph = 1; left = CLR; end
           else begin
             e_valid = 1; e_data = {11'd0, i_data}; left = left - 1;
             if (left == 0) begin ph = 4; left = DRN; end
           end
         end
      4: begin left = left - 1; if (left == 0) ph = 5; end
      5: begin
           hist.push_back(i_colors);
           if (agree() || hist.size() == MAXF) begin ph = 6; e_colors = i_colors; e_stable = agree(); end
           else begin ph = 1; left = CLR; end
         end
      6: if (i_ack) ph = 0;
      default: ph = 0;
    endcase
    e_busy = ph != 0; e_rstn = ph != 1; e_done = ph == 6;
  end

  always @(negedge i_clk) begin
    if (m_ok) begin
      chk("busy", o_busy, e_busy);
      chk("det_rstn", o_det_rstn, e_rstn);
      chk("done", o_done, e_done);
      chk("det_valid", o_det_valid, e_valid);
      if (e_valid) chk("det_data", o_det_data, e_data);
      chk("colors", o_colors, e_colors);
      chk("stable", o_stable, e_stable);
    end
    n_valid += int'(o_det_valid);
    if (!o_det_rstn) n_low++;
  end

  logic [26:0] cols[8];

  task automatic send_px(input logic sof);
    int g;
    g = $urandom_range(0, 2);
    repeat (g) begin @(negedge i_clk); i_valid = 0; i_sof = 1'($urandom_range(0, 1)); end
    @(negedge i_clk);
    i_valid = 1; i_sof = sof; i_data = 16'($urandom); i_start = ($urandom_range(0, 7) == 0);
  endtask

  task automatic idle_in();
    @(negedge i_clk); i_valid = 0; i_sof = 0; i_start = 0;
  endtask

  task automatic wait_phase(output bit d);
    int t;
    t = 0; d = 0;
    while (o_det_rstn && !o_done && t < 300) begin @(negedge i_clk); t++; end
    if (o_done) begin d = 1; return; end
    while (!o_det_rstn && t < 300) begin @(negedge i_clk); t++; end
    if (t >= 300) begin
      checks++; errors++; d = 1;
      $display("FAIL wait_phase: timed out, got busy=%0b expected clear or done", o_busy);
    end
  endtask

  task automatic full_frame(input int pre);
    int n0;
    n0 = n_valid;
    repeat (pre) send_px(0);
    send_px(1);
    repeat (FP - 1) send_px(0);
    idle_in(); idle_in();
    chk("fwd_per_frame", n_valid - n0, FP);
  endtask

  task automatic short_frame();
    int n0;
    n0 = n_valid;
    send_px(1);
    repeat (9) send_px(0);
    send_px(1);
    idle_in();
    chk("fwd_short_frame", n_valid - n0, 10);
  endtask

  task automatic capture(input int shorts, input bit rnd);
    bit d;
    int k, s;
    k = 0; s = shorts;
    @(negedge i_clk); i_start = 1;
    @(negedge i_clk); i_start = 0;
    for (int g = 0; g < 16; g++) begin
      wait_phase(d);
      if (d) break;
      if (s > 0) begin s--; short_frame(); end
      else begin
        i_colors = rnd ? ($urandom_range(0, 1) ? CA : CB) : cols[k % 8];
        k++;
        full_frame(rnd ? $urandom_range(0, 5) : 5);
      end
    end
    chk("done_reached", o_done, 1);
  endtask

  task automatic ack();
    @(negedge i_clk); i_ack = 1;
    @(negedge i_clk); i_ack = 0;
    chk("ack_done_low", o_done, 0);
    chk("ack_busy_low", o_busy, 0);
  endtask

  initial begin
    bit d;
    int nv0, nl0;
    repeat (3) @(negedge i_clk);
    i_rstn = 1;
    @(negedge i_clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_det_rstn", o_det_rstn, 1);
    chk("rst_done", o_done, 0);
    chk("rst_colors", o_colors, 0);

    @(negedge i_clk); i_start = 1;
    @(negedge i_clk); i_start = 0;
    wait_phase(d);
    send_px(1);
    repeat (5) send_px(0);
    @(negedge i_clk); i_rstn = 0; i_valid = 0; i_start = 0;
    repeat (3) @(negedge i_clk);
    chk("midrst_valid", o_det_valid, 0);
    chk("midrst_det_rstn", o_det_rstn, 1);
    chk("midrst_done", o_done, 0);
    chk("midrst_busy", o_busy, 0);
    i_rstn = 1;

    cols[0] = CN; cols[1] = CN;
    nv0 = n_valid; nl0 = n_low;
    capture(0, 0);
    chk("nom_colors", o_colors, CN);
    chk("nom_model_colors", e_colors, 27'h1234567);
    chk("nom_stable", o_stable, 1);
    chk("nom_valid_count", n_valid - nv0, 32);
    chk("nom_clear_cycles", n_low - nl0, 4);
    ack();

    cols[0] = CA; cols[1] = CB; cols[2] = CA; cols[3] = CB;
    capture(0, 0);
    chk("unst_colors", o_colors, CB);
    chk("unst_stable", o_stable, 0);
    ack();

    capture(1, 0);
    chk("short_colors", o_colors, CB);
    chk("short_stable", o_stable, 0);
    ack();

    cols[0] = CB; cols[1] = CB;
    capture(0, 0);
    repeat (10) begin @(negedge i_clk); chk("done_held", o_done, 1); end
    i_start = 1; i_ack = 1;
    @(negedge i_clk); i_start = 0; i_ack = 0;
    chk("hs_busy", o_busy, 0);
    chk("hs_done", o_done, 0);
    repeat (3) begin @(negedge i_clk); chk("hs_stay_idle", o_busy, 0); end

    repeat (6) begin capture(0, 1); ack(); end

    @(negedge i_clk); i_start = 1;
    @(negedge i_clk); i_start = 0;
    wait_phase(d);
    send_px(1);
    repeat (4) send_px(0);
    @(negedge i_clk); i_abort = 1; i_valid = 0;
    @(negedge i_clk); i_abort = 0;
    chk("abort_busy", o_busy, 0);
    chk("abort_det_rstn", o_det_rstn, 1);
    chk("abort_valid", o_det_valid, 0);

    capture(0, 1);
    @(negedge i_clk); i_abort = 1;
    @(negedge i_clk); i_abort = 0;
    chk("abort_done", o_done, 0);
    repeat (3) @(negedge i_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got time %0t expected under 2000000", $time);
    $fatal(1);
  end
endmodule
